ex_stage: RTL

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage -- execute stage of the pipeline with an iterative shift-add multiplier.
//
// Purpose:
//    - Selects forwarded operands and runs the single-cycle ALU.
//    - Registers the result, the store data and the controls into EX/MEM.
//    - MUL stalls the front end while a multi-cycle shift-add multiply runs.
//
// Ports:
//    clk, rst_n                       clock, async active-low reset
//    id_ex_*                          ID/EX instruction fields
//    ForwardA / ForwardB              operand source: 00 ID/EX, 01 EX/MEM, 10 WB, 11 ID/EX
//    select                           store data taken from EX/MEM result
//    wb_data                          write-back value used for forwarding
//    flush                            kill the ID/EX instruction and any multiply
//    ex_mem_*                         registered EX/MEM outputs
//    stall_out                        freeze IF/ID and ID/EX (combinational)
//    mul_busy                         multiplier FSM not idle
//
// Multiplier FSM:
//    state  | meaning
//    IDLE   | no multiply; single-cycle ops flow through, MUL issue stalls
//    BUSY   | one shift-add iteration per cycle, down-counter to terminal count
//    DONE   | product written to EX/MEM with the latched controls, stall released
module ex_stage #(
   parameter int DATA_W     = 16,
   parameter int MUL_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_ex_valid,
   input  logic              id_ex_reg_write,
   input  logic              id_ex_mem_write,
   input  logic              id_ex_mem_read,
   input  logic [3:0]        id_ex_alu_op,
   input  logic              id_ex_alu_src,
   input  logic [DATA_W-1:0] id_ex_rs1_data,
   input  logic [DATA_W-1:0] id_ex_rs2_data,
   input  logic [DATA_W-1:0] id_ex_imm,
   input  logic [3:0]        id_ex_write_address,
   input  logic [1:0]        ForwardA,
   input  logic [1:0]        ForwardB,
   input  logic              select,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   output logic              ex_mem_valid,
   output logic              ex_mem_reg_write,
   output logic              ex_mem_mem_write,
   output logic              ex_mem_mem_read,
   output logic [DATA_W-1:0] ex_mem_alu_result,
   output logic [DATA_W-1:0] ex_mem_store_data,
   output logic [3:0]        ex_mem_write_address,
   output logic              stall_out,
   output logic              mul_busy
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [3:0] NO_WRITE = 4'b1111;
   localparam logic [3:0] OP_MUL   = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] op_a, raw_b, op_b, st_data, alu_res;
   logic              mul_issue, mul_start;

   logic [DATA_W-1:0] mcand, mplier, acc;
   logic [CNT_W-1:0]  cnt;
   logic              m_reg_write, m_mem_write, m_mem_read;
   logic [3:0]        m_addr;
   logic [DATA_W-1:0] m_store;

   logic              nxt_valid, nxt_reg_write, nxt_mem_write, nxt_mem_read;
   logic [DATA_W-1:0] nxt_result, nxt_store;
   logic [3:0]        nxt_addr;

   // operand selection; ForwardX = 11 falls back to the ID/EX value
   always_comb begin
      case (ForwardA)
         2'b01:   op_a = ex_mem_alu_result;
         2'b10:   op_a = wb_data;
         default: op_a = id_ex_rs1_data;
      endcase
      case (ForwardB)
         2'b01:   raw_b = ex_mem_alu_result;
         2'b10:   raw_b = wb_data;
         default: raw_b = id_ex_rs2_data;
      endcase
      op_b    = id_ex_alu_src ? id_ex_imm : raw_b;
      st_data = select ? ex_mem_alu_result : raw_b;
   end

   always_comb begin
      alu_res = '0;
      case (id_ex_alu_op)
         4'd0:    alu_res = op_a + op_b;
         4'd1:    alu_res = op_a - op_b;
         4'd2:    alu_res = op_a & op_b;
         4'd3:    alu_res = op_a | op_b;
         4'd4:    alu_res = op_a ^ op_b;
         4'd5:    alu_res = op_a << op_b[3:0];
         4'd6:    alu_res = op_a >> op_b[3:0];
         4'd7:    alu_res = $unsigned($signed(op_a) >>> op_b[3:0]);
         4'd8:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         4'd9:    alu_res = op_b;
         default: alu_res = '0;
      endcase
   end

   assign mul_issue = id_ex_valid && (id_ex_alu_op == OP_MUL);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (mul_issue && !flush) state_nxt = S_BUSY;
         S_BUSY: begin
            if (flush)            state_nxt = S_IDLE;
            else if (cnt == '0)   state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs; reset gating keeps stall_out low while rst_n is held
   always_comb begin
      mul_start = (state == S_IDLE) && mul_issue && !flush;
      stall_out = rst_n && (mul_start || (state == S_BUSY));
      mul_busy  = (state != S_IDLE);
   end

   // shift-add datapath and the controls captured at issue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         cnt         <= '0;
         m_reg_write <= 1'b0;
         m_mem_write <= 1'b0;
         m_mem_read  <= 1'b0;
         m_addr      <= NO_WRITE;
         m_store     <= '0;
      end else if (mul_start) begin
         mcand       <= op_a;
         mplier      <= op_b;
         acc         <= '0;
         cnt         <= CNT_W'(MUL_CYCLES - 1);
         m_reg_write <= id_ex_reg_write;
         m_mem_write <= id_ex_mem_write;
         m_mem_read  <= id_ex_mem_read;
         m_addr      <= id_ex_write_address;
         m_store     <= st_data;
      end else if (state == S_BUSY && !flush) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
   end

   // EX/MEM next value; flush dominates, then the finished product, then stall bubbles
   always_comb begin
      nxt_valid     = 1'b0;
      nxt_reg_write = 1'b0;
      nxt_mem_write = 1'b0;
      nxt_mem_read  = 1'b0;
      nxt_result    = '0;
      nxt_store     = '0;
      nxt_addr      = NO_WRITE;
      if (flush) begin
         nxt_valid = 1'b0;
      end else if (state == S_DONE) begin
         nxt_valid     = 1'b1;
         nxt_reg_write = m_reg_write && (m_addr != NO_WRITE);
         nxt_mem_write = m_mem_write;
         nxt_mem_read  = m_mem_read;
         nxt_result    = acc;
         nxt_store     = m_store;
         nxt_addr      = m_addr;
      end else if (!stall_out && id_ex_valid) begin
         nxt_valid     = 1'b1;
         nxt_reg_write = id_ex_reg_write && (id_ex_write_address != NO_WRITE);
         nxt_mem_write = id_ex_mem_write;
         nxt_mem_read  = id_ex_mem_read;
         nxt_result    = alu_res;
         nxt_store     = st_data;
         nxt_addr      = id_ex_write_address;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_mem_valid         <= 1'b0;
         ex_mem_reg_write     <= 1'b0;
         ex_mem_mem_write     <= 1'b0;
         ex_mem_mem_read      <= 1'b0;
         ex_mem_alu_result    <= '0;
         ex_mem_store_data    <= '0;
         ex_mem_write_address <= NO_WRITE;
      end else begin
         ex_mem_valid         <= nxt_valid;
         ex_mem_reg_write     <= nxt_reg_write;
         ex_mem_mem_write     <= nxt_mem_write;
         ex_mem_mem_read      <= nxt_mem_read;
         ex_mem_alu_result    <= nxt_result;
         ex_mem_store_data    <= nxt_store;
         ex_mem_write_address <= nxt_addr;
      end
   end

endmodule
